// File: rtl/button_event_classifier_pkg.sv
// Shared types and elaboration-time helpers for the button event classifier.
// Package name: btn_evt_pkg.
package btn_evt_pkg;

  // Gesture FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSED  = 2'd1,
    WAIT_GAP = 2'd2,
    HOLD     = 2'd3
  } btn_state_e;

  // Clock cycles in one millisecond; the clock must be a multiple of 1 kHz.
  function automatic int cycles_per_ms(input int freq);
    return freq / 1000;
  endfunction

  // Millisecond counter width: wide enough to hold the largest timeout.
  function automatic int ms_cnt_width(input int long_ms, input int gap_ms, input int rep_ms);
    int m;
    m = long_ms;
    if (gap_ms > m) m = gap_ms;
    if (rep_ms > m) m = rep_ms;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_event_classifier_if.sv
// Event bus between the debouncer-facing bench/application and the classifier.
// master drives the debounced strobe/level; slave (the classifier) drives the pulses.
interface button_event_classifier_if;
  logic in_valid;
  logic in_level;
  logic short_press;
  logic long_press;
  logic double_click;
  logic repeat_press;
  logic busy;

  modport master (
    output in_valid, in_level,
    input  short_press, long_press, double_click, repeat_press, busy
  );

  modport slave (
    input  in_valid, in_level,
    output short_press, long_press, double_click, repeat_press, busy
  );
endinterface

// File: rtl/button_event_classifier_ms_tick.sv
// Millisecond prescaler: tick is high for one cycle every CPM clocks after the
// last synchronous clear. tick is not gated by clr so the parent can derive
// clr from tick without a combinational loop.
module btn_ms_tick #(
  parameter int CPM = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (CPM > 1) ? $clog2(CPM) : 1;
  localparam logic [PW-1:0] LAST = PW'(CPM - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Next prescaler value: restart on clear or on wrap.
  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/button_event_classifier.sv
// Classifies debounced button gestures into short press, long press and
// double click 1-cycle pulses. Optional auto-repeat while a long press is held
// is enabled with the macro BTN_EVT_REPEAT_EN.
module button_event_classifier
  import btn_evt_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 10_000_000,
  parameter int LONG_PRESS_MS   = 1000,
  parameter int DOUBLE_CLICK_MS = 300,
  parameter int REPEAT_MS       = 200
) (
  input  logic                        clk,
  input  logic                        rst,
  button_event_classifier_if.slave    bus
);

  localparam int CPM = cycles_per_ms(CLK_FREQ_HZ);
  localparam int MSW = ms_cnt_width(LONG_PRESS_MS, DOUBLE_CLICK_MS, REPEAT_MS);
  localparam logic [MSW-1:0] LONG_V = MSW'(LONG_PRESS_MS);
  localparam logic [MSW-1:0] GAP_V  = MSW'(DOUBLE_CLICK_MS);
  localparam logic [MSW-1:0] MS_MAX = '1;
`ifdef BTN_EVT_REPEAT_EN
  localparam logic [MSW-1:0] REP_V  = MSW'(REPEAT_MS);
`endif

  btn_state_e     state_q, state_d;
  logic [MSW-1:0] ms_q, ms_d;
  logic [MSW-1:0] ms_inc;
  logic           short_q, short_d;
  logic           long_q, long_d;
  logic           dbl_q, dbl_d;
  logic           tick;
  logic           timer_clr;
  logic           restart;
  logic           press_ev;
  logic           release_ev;
  logic           long_hit;
  logic           gap_hit;
`ifdef BTN_EVT_REPEAT_EN
  logic           rep_q, rep_d;
  logic           from_long_q, from_long_d;
  logic           rep_hit;
`endif

  assign press_ev   = bus.in_valid &  bus.in_level;
  assign release_ev = bus.in_valid & ~bus.in_level;

  // A timeout is reached on the tick that moves the ms counter onto its value,
  // so the deciding edge lands exactly X*CPM clocks after state entry.
  assign ms_inc   = ms_q + MSW'(1);
  assign long_hit = tick && (ms_inc == LONG_V);
  assign gap_hit  = tick && (ms_inc == GAP_V);
`ifdef BTN_EVT_REPEAT_EN
  assign rep_hit  = tick && (ms_inc == REP_V);
`endif

  btn_ms_tick #(.CPM(CPM)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .tick (tick)
  );

  // Next-state and pulse decode; input events are tested before timeouts so
  // they win a same-cycle collision.
  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    restart = 1'b0;
`ifdef BTN_EVT_REPEAT_EN
    rep_d       = 1'b0;
    from_long_d = from_long_q;
`endif
    case (state_q)
      IDLE: begin
        if (press_ev) state_d = PRESSED;
      end
      PRESSED: begin
        if (release_ev) begin
          state_d = WAIT_GAP;
        end else if (long_hit) begin
          long_d  = 1'b1;
          state_d = HOLD;
`ifdef BTN_EVT_REPEAT_EN
          from_long_d = 1'b1;
`endif
        end
      end
      WAIT_GAP: begin
        if (press_ev) begin
          dbl_d   = 1'b1;
          state_d = HOLD;
`ifdef BTN_EVT_REPEAT_EN
          from_long_d = 1'b0;
`endif
        end else if (gap_hit) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (release_ev) begin
          state_d = IDLE;
`ifdef BTN_EVT_REPEAT_EN
        end else if (from_long_q && rep_hit) begin
          rep_d   = 1'b1;
          restart = 1'b1;
`endif
        end
      end
    endcase
    timer_clr = (state_d != state_q) || restart;
  end

  // Millisecond counter: cleared with the prescaler, saturates at all-ones.
  always_comb begin
    ms_d = ms_q;
    if (timer_clr)                 ms_d = '0;
    else if (tick && ms_q != MS_MAX) ms_d = ms_inc;
  end

  // FSM, timer and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ms_q    <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      rep_q       <= 1'b0;
      from_long_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
`ifdef BTN_EVT_REPEAT_EN
      rep_q       <= rep_d;
      from_long_q <= from_long_d;
`endif
    end
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_click = dbl_q;
  assign bus.busy         = (state_q != IDLE);
`ifdef BTN_EVT_REPEAT_EN
  assign bus.repeat_press = rep_q;
`else
  assign bus.repeat_press = 1'b0;
`endif

endmodule

// File: doc/button_event_classifier.md
Name: button_event_classifier

Overview:
- Sits directly downstream of the debouncer (debounce_ip_core). Consumes its change strobe and debounced level.
- Classifies each button gesture as short press, long press or double click. Emits each as a 1-cycle pulse for application logic such as LED toggling or mode select.
- One timing engine: a 1 ms tick prescaler feeding a millisecond counter, driven by a 4-state FSM.

Parameters:
- CLK_FREQ_HZ, 10_000_000, system clock frequency. Must be a multiple of 1000; CPM = CLK_FREQ_HZ/1000 cycles per ms.
- LONG_PRESS_MS, 1000, hold time (ms) at which a press is classified long. Range 1..65535.
- DOUBLE_CLICK_MS, 300, maximum gap (ms) between a release and a second press for a double click. Range 1..65535.
- REPEAT_MS, 200, auto-repeat period (ms). Used only with BTN_EVT_REPEAT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  1-cycle strobe from the debouncer on every debounced level change
- in_level  in  1  debounced level, 1 = pressed; sampled only when in_valid=1
- short_press  out  1  1-cycle pulse: single press, released before LONG_PRESS_MS, no second press within DOUBLE_CLICK_MS
- long_press  out  1  1-cycle pulse: hold reached LONG_PRESS_MS
- double_click  out  1  1-cycle pulse: second press within DOUBLE_CLICK_MS of first release
- repeat_press  out  1  1-cycle auto-repeat pulse; constant 0 without BTN_EVT_REPEAT_EN
- busy  out  1  1 when FSM is not IDLE

Behaviour:
- Interface (decided): one clock clk; asynchronous, active-high reset rst.
- Reset: FSM=IDLE, ms counter=0, prescaler=0. All outputs 0.
- A reset asserted mid-gesture discards the gesture; no pulse is emitted afterwards.
- All outputs are registered. A pulse is high for exactly one cycle, in the cycle after the deciding clock edge.
- Press event = in_valid&in_level. Release event = in_valid&~in_level.
- Timer: prescaler and ms counter are synchronously cleared on every state entry. A tick fires every CPM cycles after the clear.
- "Reaches X ms" = the ms counter equals X on a tick, i.e. exactly X*CPM clocks after the entering edge.
- ms counter width: $clog2(max(LONG_PRESS_MS, DOUBLE_CLICK_MS, REPEAT_MS)+1). It saturates and never wraps.
- State IDLE:
  - press -> PRESSED.
  - Release ignored.
- State PRESSED:
  - release -> WAIT_GAP.
  - Reaches LONG_PRESS_MS -> long_press pulse, -> HOLD.
- State WAIT_GAP:
  - press -> double_click pulse, -> HOLD.
  - Reaches DOUBLE_CLICK_MS -> short_press pulse, -> IDLE.
- State HOLD:
  - release -> IDLE, no pulse.
  - A press strobe here (redundant) is ignored.
- Simultaneous input event and timer expiry in the same cycle: the input event wins.
  - PRESSED: release at the LONG tick -> WAIT_GAP, no long_press.
  - WAIT_GAP: press at the timeout tick -> double_click, no short_press.
- Strobes whose level matches the current state's expectation are ignored (e.g. a press in PRESSED).
- At most one of short_press/long_press/double_click is high in any cycle.
- busy = (state != IDLE). It is combinational from the state register.
- Latency summary (CPM clocks per ms):
  - long_press: LONG_PRESS_MS*CPM clocks after the press edge.
  - short_press: DOUBLE_CLICK_MS*CPM clocks after the release edge.
  - double_click: 1 cycle after the second press edge.

Optional Feature:
- Macro: BTN_EVT_REPEAT_EN.
- Defined: HOLD entered via long_press emits repeat_press every REPEAT_MS while held.
  - First repeat pulse comes REPEAT_MS after long_press; the timer is cleared after each repeat.
  - Release stops repeating immediately.
  - HOLD entered via double_click never repeats (a 1-bit flag records the entry path).
- Undefined: repeat_press is tied to 0 and there is no repeat logic or flag.

Decomposition:
- Package btn_evt_pkg holds:
  - state typedef enum {IDLE, PRESSED, WAIT_GAP, HOLD}, 2-bit encoding;
  - function cycles_per_ms(freq);
  - function ms_cnt_width(long, gap, rep).
- Sub-module btn_ms_tick: prescaler with synchronous clr input and 1-cycle tick output every CPM clocks after clr. Instanced once.

Test Plan:
- Bench parameters: CLK_FREQ_HZ=10_000 (CPM=10), LONG_PRESS_MS=5, DOUBLE_CLICK_MS=3, REPEAT_MS=2.
- Short press: press at edge 0, release at edge 20 -> short_press high for exactly 1 cycle after edge 50. No other pulses.
- Long press: press at edge 0, held -> long_press 1 cycle after edge 50. Release at edge 200 -> no further pulse; busy falls after the release edge.
- Double click: press at 0, release at 10, press at 35 -> double_click 1 cycle after edge 35. Release at 40 -> IDLE, no short_press ever.
- Tie-break: press at 0, release exactly at edge 50 -> no long_press; short_press after edge 80. Then press exactly at the WAIT_GAP timeout edge -> double_click wins.
- Reset mid-gesture: press at 0, rst pulsed at edge 20 -> all outputs 0 immediately, busy=0. No pulse emitted up to edge 200.
- BTN_EVT_REPEAT_EN defined: press held 0..120 -> long_press after 50; repeat_press after 70, 90, 110. None after release at 120.
- Undefined: repeat_press stays 0 throughout.
